writeback_regfile: RTL and testbench

Writeback-stage block that consumes the registered outputs of the MEM/WB pipeline register and commits results to the architectural register file. It selects the writeback datum, performs the register write, and serves two read ports to decode with same-cycle write-to-read bypass. It also latches processor halt and counts retired instructions. It sits between the MEM/WB pipeline register and the decode stage and hazard/forwarding logic.

---
 rtl/writeback_regfile_if.sv | 40 ++++
 rtl/writeback_regfile.sv | 80 ++++++++
 tb/tb_writeback_regfile.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_regfile_if.sv
// MEM/WB entry, decode read ports and writeback
// observation signals bundled for the writeback stage.
interface writeback_regfile_if #(
  parameter int IDX_W  = 5,
  parameter int WORD_W = 32
);
  logic              valid_i;
  logic [1:0]        rfInSel_i;
  logic [IDX_W-1:0]  wsel_i;
  logic              rfWEN_i;
  logic [WORD_W-1:0] aluout_i;
  logic [WORD_W-1:0] dmemload_i;
  logic [WORD_W-1:0] pipe_npc_i;
  logic [WORD_W-1:0] lui32_i;
  logic              halt_i;
  logic [IDX_W-1:0]  rsel1_i;
  logic [IDX_W-1:0]  rsel2_i;
  logic [WORD_W-1:0] rdat1_o;
  logic [WORD_W-1:0] rdat2_o;
  logic [WORD_W-1:0] wdat_o;
  logic              wen_o;
  logic              halted_o;
  logic [31:0]       retired_o;

  modport master (
    output valid_i, rfInSel_i, wsel_i, rfWEN_i,
    output aluout_i, dmemload_i, pipe_npc_i,
    output lui32_i, halt_i, rsel1_i, rsel2_i,
    input  rdat1_o, rdat2_o, wdat_o, wen_o,
    input  halted_o, retired_o
  );

  modport slave (
    input  valid_i, rfInSel_i, wsel_i, rfWEN_i,
    input  aluout_i, dmemload_i, pipe_npc_i,
    input  lui32_i, halt_i, rsel1_i, rsel2_i,
    output rdat1_o, rdat2_o, wdat_o, wen_o,
    output halted_o, retired_o
  );
endinterface

// File: rtl/writeback_regfile.sv
// Writeback stage: selects the result, commits it to the
// register file, bypasses reads, latches halt, counts retires.
module writeback_regfile #(
  parameter int NREGS  = 32,
  parameter int WORD_W = 32
) (
  input logic                 CLK,
  input logic                 nRST,
  writeback_regfile_if.slave  wb
);
  localparam int IDX_W = $clog2(NREGS);

  logic [WORD_W-1:0] regs_q [NREGS];
  logic              halted_q, halted_d;
  logic [31:0]       retired_q, retired_d;
  logic [WORD_W-1:0] wdat;
  logic              wen;
  logic              retire;

  always_comb begin
    wdat = '0;
    unique case (wb.rfInSel_i)
      2'd0: wdat = wb.aluout_i;
      2'd1: wdat = wb.dmemload_i;
      2'd2: wdat = wb.pipe_npc_i;
      2'd3: wdat = wb.lui32_i;
      default: wdat = '0;
    endcase
  end

  // nRST gates the bypass so reads stay zero while in reset
  assign wen = nRST & wb.valid_i & wb.rfWEN_i
             & (wb.wsel_i != '0) & ~halted_q;

  assign retire = wb.valid_i & ~halted_q;

  always_comb begin
    halted_d  = halted_q;
    retired_d = retired_q;
    if (wb.valid_i && wb.halt_i && !halted_q)
      halted_d = 1'b1;
    if (retire)
      retired_d = retired_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= '0;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      if (wen)
        regs_q[wb.wsel_i] <= wdat;
      halted_q  <= halted_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    wb.rdat1_o = regs_q[wb.rsel1_i];
    if (wb.rsel1_i == IDX_W'(0))
      wb.rdat1_o = '0;
    else if (wen && wb.wsel_i == wb.rsel1_i)
      wb.rdat1_o = wdat;
  end

  always_comb begin
    wb.rdat2_o = regs_q[wb.rsel2_i];
    if (wb.rsel2_i == IDX_W'(0))
      wb.rdat2_o = '0;
    else if (wen && wb.wsel_i == wb.rsel2_i)
      wb.rdat2_o = wdat;
  end

  assign wb.wdat_o    = wdat;
  assign wb.wen_o     = wen;
  assign wb.halted_o  = halted_q;
  assign wb.retired_o = retired_q;
endmodule

// File: tb/tb_writeback_regfile.sv
// Bench for writeback_regfile: directed table, hand
// sequences for halt/reset/wrap, randomized model checks.
module tb_writeback_regfile;
  logic CLK;
  logic nRST;
  int   n_pass;
  int   n_total;

  writeback_regfile_if bus ();

  writeback_regfile dut (
    .CLK  (CLK),
    .nRST (nRST),
    .wb   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        v;
    logic [1:0]  sel;
    logic [4:0]  ws;
    logic        we;
    logic [31:0] alu;
    logic [31:0] dm;
    logic [31:0] npc;
    logic [31:0] lui;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        ew;
  } vec_t;

  logic [31:0] m_regs [32];
  bit          m_halt;
  logic [31:0] m_ret;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic logic [31:0] m_src();
    logic [31:0] s [4];
    s[0] = bus.aluout_i;
    s[1] = bus.dmemload_i;
    s[2] = bus.pipe_npc_i;
    s[3] = bus.lui32_i;
    return s[bus.rfInSel_i];
  endfunction

  function automatic bit m_wen();
    return nRST && bus.valid_i && bus.rfWEN_i
      && bus.wsel_i != 0 && !m_halt;
  endfunction

  function automatic logic [31:0] m_rd(logic [4:0] idx);
    if (idx == 0) return 0;
    if (m_wen() && bus.wsel_i == idx) return m_src();
    return m_regs[idx];
  endfunction

  task automatic m_clear();
    foreach (m_regs[i]) m_regs[i] = 0;
    m_halt = 0;
    m_ret  = 0;
  endtask

  task automatic check_model(string tag);
    chk({tag, ".wdat"}, bus.wdat_o, m_src());
    chk({tag, ".wen"}, 32'(bus.wen_o), 32'(m_wen()));
    chk({tag, ".rdat1"}, bus.rdat1_o, m_rd(bus.rsel1_i));
    chk({tag, ".rdat2"}, bus.rdat2_o, m_rd(bus.rsel2_i));
    chk({tag, ".halted"}, 32'(bus.halted_o), 32'(m_halt));
    chk({tag, ".retired"}, bus.retired_o, m_ret);
  endtask

  task automatic edge_step();
    bit w;
    @(posedge CLK);
    w = m_wen();
    if (nRST) begin
      if (w) m_regs[bus.wsel_i] = m_src();
      if (bus.valid_i && !m_halt) begin
        m_ret = m_ret + 1;
        if (bus.halt_i) m_halt = 1;
      end
    end
    #1;
  endtask

  task automatic drive(logic v, logic [1:0] sel,
      logic [4:0] ws, logic we, logic [31:0] alu,
      logic [31:0] dm, logic [31:0] npc,
      logic [31:0] lui, logic h, logic [4:0] r1,
      logic [4:0] r2);
    bus.valid_i    = v;
    bus.rfInSel_i  = sel;
    bus.wsel_i     = ws;
    bus.rfWEN_i    = we;
    bus.aluout_i   = alu;
    bus.dmemload_i = dm;
    bus.pipe_npc_i = npc;
    bus.lui32_i    = lui;
    bus.halt_i     = h;
    bus.rsel1_i    = r1;
    bus.rsel2_i    = r2;
  endtask

  task automatic mid_reset(string tag);
    #2 nRST = 1'b0;
    m_clear();
    #1;
    check_model({tag, ".inrst"});
    chk({tag, ".rst_halted"}, 32'(bus.halted_o), 0);
    chk({tag, ".rst_ret"}, bus.retired_o, 0);
    #1 nRST = 1'b1;
    edge_step();
  endtask

  vec_t vec [7];

  initial begin
    n_pass  = 0;
    n_total = 0;
    m_clear();
    nRST = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 1);
    #2;
    check_model("reset");
    chk("reset.ret", bus.retired_o, 0);
    @(posedge CLK);
    @(posedge CLK);
    #1 nRST = 1'b1;

    vec[0] = '{1'b1, 2'd0, 5'd5, 1'b1, 32'hDEAD_BEEF,
               32'hA0, 32'hA1, 32'hA2, 5'd5, 5'd0,
               32'hDEAD_BEEF, 32'h0, 1'b1};
    vec[1] = '{1'b1, 2'd0, 5'd1, 1'b1, 32'h1,
               32'hB0, 32'hB1, 32'hB2, 5'd5, 5'd1,
               32'hDEAD_BEEF, 32'h1, 1'b1};
    vec[2] = '{1'b1, 2'd1, 5'd2, 1'b1, 32'hC0,
               32'h2, 32'hC1, 32'hC2, 5'd1, 5'd2,
               32'h1, 32'h2, 1'b1};
    vec[3] = '{1'b1, 2'd2, 5'd3, 1'b1, 32'hD0,
               32'hD1, 32'h3, 32'hD2, 5'd2, 5'd3,
               32'h2, 32'h3, 1'b1};
    vec[4] = '{1'b1, 2'd3, 5'd4, 1'b1, 32'hE0,
               32'hE1, 32'hE2, 32'h1234_0000, 5'd3, 5'd4,
               32'h3, 32'h1234_0000, 1'b1};
    vec[5] = '{1'b0, 2'd0, 5'd4, 1'b1, 32'h99,
               32'h98, 32'h97, 32'h96, 5'd4, 5'd4,
               32'h1234_0000, 32'h1234_0000, 1'b0};
    vec[6] = '{1'b1, 2'd0, 5'd0, 1'b1, 32'hFFFF_FFFF,
               32'h55, 32'h66, 32'h77, 5'd0, 5'd5,
               32'h0, 32'hDEAD_BEEF, 1'b0};

    for (int i = 0; i < 7; i++) begin
      drive(vec[i].v, vec[i].sel, vec[i].ws, vec[i].we,
            vec[i].alu, vec[i].dm, vec[i].npc, vec[i].lui,
            1'b0, vec[i].r1, vec[i].r2);
      #3;
      chk($sformatf("vec%0d.rdat1", i), bus.rdat1_o,
          vec[i].e1);
      chk($sformatf("vec%0d.rdat2", i), bus.rdat2_o,
          vec[i].e2);
      chk($sformatf("vec%0d.wen", i), 32'(bus.wen_o),
          32'(vec[i].ew));
      check_model($sformatf("vec%0d", i));
      edge_step();
    end
    chk("table.retired", bus.retired_o, 32'd6);

    // HALT, then a write attempt that must be dropped
    drive(1, 0, 7, 0, 32'h70, 0, 0, 0, 1, 7, 5);
    #3;
    chk("halt.cycle_halted", 32'(bus.halted_o), 0);
    check_model("halt");
    edge_step();
    chk("halt.after", 32'(bus.halted_o), 1);
    chk("halt.retired", bus.retired_o, 32'd7);
    drive(1, 0, 7, 1, 32'h77, 0, 0, 0, 0, 7, 4);
    #3;
    chk("halted.wen", 32'(bus.wen_o), 0);
    check_model("halted_wr");
    edge_step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 4);
    #3;
    chk("halted.reg7", bus.rdat1_o, 0);
    chk("halted.reg4", bus.rdat2_o, 32'h1234_0000);
    chk("halted.frozen", bus.retired_o, 32'd7);
    check_model("halted_rd");

    mid_reset("rst1");
    drive(1, 0, 9, 1, 32'h0909, 0, 0, 0, 0, 9, 5);
    #3;
    check_model("postrst_wr");
    edge_step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 5);
    #3;
    chk("postrst.reg9", bus.rdat1_o, 32'h0909);
    chk("postrst.reg5", bus.rdat2_o, 0);
    check_model("postrst_rd");
    edge_step();

    for (int i = 0; i < 400; i++) begin
      logic h;
      logic we;
      logic [4:0] ws;
      ws = 5'($urandom_range(0, 31));
      h  = ($urandom_range(0, 79) == 0);
      we = h ? 1'b0 : 1'($urandom);
      drive(1'($urandom_range(0, 3) != 0),
            2'($urandom), ws, we, $urandom, $urandom,
            $urandom, $urandom, h,
            ($urandom_range(0, 3) == 0) ? ws
              : 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)));
      #3;
      check_model($sformatf("rnd%0d", i));
      edge_step();
      if (i % 97 == 96) mid_reset($sformatf("rrst%0d", i));
    end

    // wrap: preload the counter just below the limit
    mid_reset("rst_wrap");
    force dut.retired_q = 32'hFFFF_FFFE;
    #1 release dut.retired_q;
    m_ret = 32'hFFFF_FFFE;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check_model("wrap0");
    edge_step();
    #2;
    chk("wrap.max", bus.retired_o, 32'hFFFF_FFFF);
    check_model("wrap1");
    edge_step();
    #2;
    chk("wrap.zero", bus.retired_o, 32'h0);
    check_model("wrap2");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
